// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Serves one operation at a time: accept, capture the result, then hold the response until it is consumed.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; grant one requester combinationally
// EXEC  | latched operands drive the ALU; capture result and flags
// RESP  | present result to the granted requester until rspN_ready
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] OP_LAST_LEGAL = 3'b100;

    logic [1:0]       state;
    logic             last_grant;
    logic             gnt_idx;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [2:0]       opnd_op;

    logic             any_valid;
    logic             pick;
    logic             accept;
    logic             op_illegal;
    logic             rsp_taken;

    // With both requesting, the one not served last wins; a lone requester always wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            pick = ~last_grant;
        end else begin
            pick = req1_valid;
        end
    end

    assign accept     = (state == IDLE) && any_valid;
    assign req0_ready = accept && !pick;
    assign req1_ready = accept && pick;

    assign rsp0_valid = (state == RESP) && !gnt_idx;
    assign rsp1_valid = (state == RESP) && gnt_idx;
    assign rsp_taken  = gnt_idx ? rsp1_ready : rsp0_ready;

    assign alu_a      = opnd_a;
    assign alu_b      = opnd_b;
    assign alu_op     = opnd_op;
    assign op_illegal = (opnd_op > OP_LAST_LEGAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt_idx    <= 1'b0;
            opnd_a     <= '0;
            opnd_b     <= '0;
            opnd_op    <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opnd_a     <= pick ? req1_a : req0_a;
                        opnd_b     <= pick ? req1_b : req0_b;
                        opnd_op    <= pick ? req1_op : req0_op;
                        gnt_idx    <= pick;
                        last_grant <= pick;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal ops are still sequenced but report a fixed error response.
                    if (op_illegal) begin
                        rsp_result <= '0;
                        rsp_zero   <= 1'b0;
                        rsp_err    <= 1'b1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_taken) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of grant order, latency and results.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, rsp_err;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Shared ALU in the environment; illegal ops produce junk so the DUT must mask it.
    always_comb begin
        alu_result = '0;
        alu_zero   = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 1 : 0;
            default: alu_result = (alu_a ^ ~alu_b) | 32'hDEAD_0000;
        endcase
        alu_zero = (alu_op > 3'b100) ? 1'b1 : (alu_result == '0);
    end

    // Expected response {err, zero, result} for one operation.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        logic [W-1:0] r;
        if (op > 3'd4) return {1'b1, 1'b0, {W{1'b0}}};
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            default: r = ($signed(a) < $signed(b)) ? 1 : 0;
        endcase
        return {1'b0, (r == 0), r};
    endfunction

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_op = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset;
        @(negedge clk); #1;
        tests_run++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: got %b expected 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        tests_run++;
        if ({alu_a, alu_b, alu_op, rsp_result, rsp_zero, rsp_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_regs: alu_a=%h alu_b=%h alu_op=%h res=%h z=%b e=%b expected all 0",
                     alu_a, alu_b, alu_op, rsp_result, rsp_zero, rsp_err);
        end
    endtask

    task automatic test_single_add;
        apply_reset;
        @(negedge clk);
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 3'b000; rsp0_ready = 1;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL add_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk); req0_valid = 0; #1;
        tests_run++;
        if (rsp0_valid !== 1'b0 || alu_a !== 5 || alu_b !== 7 || alu_op !== 3'b000) begin
            tests_failed++;
            $display("FAIL add_exec: rsp0_valid=%b alu_a=%0d alu_b=%0d op=%b expected 0,5,7,000",
                     rsp0_valid, alu_a, alu_b, alu_op);
        end
        @(negedge clk); #1;
        tests_run++;
        if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_err} !== 4'b1000 || rsp_result !== 12) begin
            tests_failed++;
            $display("FAIL add_resp: v0v1ze=%b result=%0d expected 1000 result=12",
                     {rsp0_valid, rsp1_valid, rsp_zero, rsp_err}, rsp_result);
        end
        @(negedge clk); #1;
        tests_run++;
        if (rsp0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_done: rsp0_valid=%b expected 0", rsp0_valid);
        end
        rsp0_ready = 0;
    endtask

    task automatic test_sub_equal;
        apply_reset;
        @(negedge clk);
        req1_valid = 1; req1_a = 9; req1_b = 9; req1_op = 3'b001; rsp1_ready = 1;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL sub_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        @(negedge clk); req1_valid = 0;
        @(negedge clk); #1;
        tests_run++;
        if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_err} !== 4'b0110 || rsp_result !== 0) begin
            tests_failed++;
            $display("FAIL sub_resp: v0v1ze=%b result=%0d expected 0110 result=0",
                     {rsp0_valid, rsp1_valid, rsp_zero, rsp_err}, rsp_result);
        end
        rsp1_ready = 0;
    endtask

    task automatic test_contention;
        logic [W-1:0] exp_res;
        apply_reset;
        @(negedge clk);
        req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 3'b010;
        req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h3C; req1_op = 3'b011;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 4; k++) begin
            exp_res = (k % 2 == 0) ? 32'h30 : 32'hFC;
            #1;
            tests_run++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                tests_failed++;
                $display("FAIL cont_grant%0d: ready=%b%b expected requester %0d", k, req0_ready, req1_ready, k % 2);
            end
            @(negedge clk); #1;
            tests_run++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0) begin
                tests_failed++;
                $display("FAIL cont_exec%0d: got %b expected 0000", k, {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
            end
            @(negedge clk); #1;
            tests_run++;
            if (rsp0_valid !== (k % 2 == 0) || rsp1_valid !== (k % 2 == 1) || rsp_result !== exp_res
                || {req0_ready, req1_ready} !== 2'b00) begin
                tests_failed++;
                $display("FAIL cont_resp%0d: v=%b%b result=%h expected requester %0d result=%h",
                         k, rsp0_valid, rsp1_valid, rsp_result, k % 2, exp_res);
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_backpressure;
        apply_reset;
        @(negedge clk);
        req0_valid = 1; req0_a = 3; req0_b = 4; req0_op = 3'b000; rsp0_ready = 0; #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept: req0_ready=%b expected 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 1; req1_a = 10; req1_b = 3; req1_op = 3'b001; rsp1_ready = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) rsp0_ready = 1;
            #1;
            tests_run++;
            if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 7 || req1_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: v=%b%b result=%0d req1_ready=%b expected v=10 result=7 ready=0",
                         k, rsp0_valid, rsp1_valid, rsp_result, req1_ready);
            end
        end
        @(negedge clk); rsp0_ready = 0; #1;
        tests_run++;
        if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_next: req1_ready=%b rsp0_valid=%b expected 1,0", req1_ready, rsp0_valid);
        end
        @(negedge clk); req1_valid = 0;
        @(negedge clk); #1;
        tests_run++;
        if (rsp1_valid !== 1'b1 || rsp_result !== 7) begin
            tests_failed++;
            $display("FAIL bp_resp1: rsp1_valid=%b result=%0d expected 1,7", rsp1_valid, rsp_result);
        end
        rsp1_ready = 0;
    endtask

    task automatic test_illegal_op;
        apply_reset;
        @(negedge clk);
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = 3'b111; rsp0_ready = 1; #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ill_accept: req0_ready=%b expected 1", req0_ready);
        end
        @(negedge clk); req0_valid = 0;
        @(negedge clk); #1;
        tests_run++;
        if (rsp0_valid !== 1'b1 || rsp_result !== 0 || rsp_zero !== 1'b0 || rsp_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL ill_resp: v=%b result=%h z=%b e=%b expected 1,0,0,1",
                     rsp0_valid, rsp_result, rsp_zero, rsp_err);
        end
        rsp0_ready = 0;
    endtask

    task automatic test_reset_mid_op;
        apply_reset;
        @(negedge clk);
        req0_valid = 1; req0_a = 5; req0_b = 6; req0_op = 3'b000; rsp0_ready = 1;
        @(negedge clk);
        req0_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_err} !== 4'b0 || rsp_result !== 0
                || alu_a !== 0 || alu_b !== 0 || alu_op !== 0) begin
                tests_failed++;
                $display("FAIL rstmid_quiet%0d: v=%b%b res=%h z=%b e=%b alu=%h/%h/%h expected all 0",
                         k, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_op);
            end
            @(negedge clk);
        end
        req0_valid = 1; req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = 3'b000; #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rstmid_grant: ready=%b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0;
    endtask

    task automatic test_random;
        logic         pend [2];
        logic [W-1:0] pa [2];
        logic [W-1:0] pb [2];
        logic [2:0]   pop [2];
        logic [W+1:0] exp_rsp;
        logic [W-1:0] exp_a, exp_b;
        bit           busy;
        bit           rv;
        int           acc_c, g, last_g, win;
        apply_reset;
        busy = 0; last_g = 1; acc_c = 0; g = 0; exp_rsp = '0; exp_a = '0; exp_b = '0;
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1;
                    pa[i]   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
                    pb[i]   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
                    pop[i]  = 3'($urandom_range(0, 7));
                end
            end
            req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
            req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            #1;
            win = -1;
            if (!busy && (pend[0] || pend[1]))
                win = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
            tests_run++;
            if (req0_ready !== (win == 0) || req1_ready !== (win == 1)) begin
                tests_failed++;
                $display("FAIL rnd_grant c%0d: ready=%b%b expected winner %0d", c, req0_ready, req1_ready, win);
            end
            rv = busy && (c >= acc_c + 2);
            tests_run++;
            if (rsp0_valid !== (rv && g == 0) || rsp1_valid !== (rv && g == 1)) begin
                tests_failed++;
                $display("FAIL rnd_valid c%0d: v=%b%b expected busy_resp=%0d owner=%0d", c, rsp0_valid, rsp1_valid, rv, g);
            end
            if (rv) begin
                tests_run++;
                if ({rsp_err, rsp_zero, rsp_result} !== exp_rsp) begin
                    tests_failed++;
                    $display("FAIL rnd_result c%0d: ezr=%b%b %h expected %b%b %h", c, rsp_err, rsp_zero, rsp_result,
                             exp_rsp[W+1], exp_rsp[W], exp_rsp[W-1:0]);
                end
                if ((g == 0) ? rsp0_ready : rsp1_ready) busy = 0;
            end
            if (busy && c == acc_c + 1) begin
                tests_run++;
                if (alu_a !== exp_a || alu_b !== exp_b) begin
                    tests_failed++;
                    $display("FAIL rnd_operands c%0d: alu=%h/%h expected %h/%h", c, alu_a, alu_b, exp_a, exp_b);
                end
            end
            if (win >= 0) begin
                busy = 1; acc_c = c; g = win; last_g = win;
                exp_rsp = ref_op(pa[win], pb[win], pop[win]);
                exp_a = pa[win]; exp_b = pb[win];
                pend[win] = 0;
            end
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        test_reset;
        test_single_add;
        test_sub_equal;
        test_contention;
        test_backpressure;
        test_illegal_op;
        test_reset_mid_op;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
